yarp_branch_redirect_ctrl: RTL and testbench



---
 rtl/yarp_branch_redirect_ctrl_if.sv | 30 +++
 rtl/yarp_branch_redirect_ctrl.sv | 94 +++++++++
 tb/tb_yarp_branch_redirect_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/yarp_branch_redirect_ctrl_if.sv
// Branch-resolution, redirect and status signals between the YARP pipeline and
// the branch redirect controller. The controller takes the master modport.
interface yarp_branch_redirect_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             br_valid_i;
  logic             br_ready_o;
  logic             br_taken_i;
  logic [31:0]      br_target_i;
  logic             stall_i;
  logic             redirect_valid_o;
  logic             redirect_ready_i;
  logic [31:0]      redirect_pc_o;
  logic             flush_o;
  logic             misalign_o;
  logic [CNT_W-1:0] resolved_cnt_o;
  logic [CNT_W-1:0] taken_cnt_o;

  modport master (
    input  br_valid_i, br_taken_i, br_target_i, stall_i, redirect_ready_i,
    output br_ready_o, redirect_valid_o, redirect_pc_o, flush_o, misalign_o,
           resolved_cnt_o, taken_cnt_o
  );

  modport slave (
    output br_valid_i, br_taken_i, br_target_i, stall_i, redirect_ready_i,
    input  br_ready_o, redirect_valid_o, redirect_pc_o, flush_o, misalign_o,
           resolved_cnt_o, taken_cnt_o
  );
endinterface

// File: rtl/yarp_branch_redirect_ctrl.sv
// Issues one PC redirect per taken, aligned branch, then flushes wrong-path
// instructions for FLUSH_CYCLES unstalled cycles; keeps saturating counters.
module yarp_branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  yarp_branch_redirect_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [3:0]       flush_cnt;
  logic [31:0]      redirect_pc;
  logic             misalign;
  logic [CNT_W-1:0] resolved_cnt;
  logic [CNT_W-1:0] taken_cnt;

  logic ready;
  logic accept;
  logic aligned;
  logic redirect_go;
  logic handshake;

  // Ready is held low while reset is asserted even though state is already IDLE.
  assign ready       = reset_n && (state == IDLE) && !bus.stall_i;
  assign accept      = bus.br_valid_i && ready;
  assign aligned     = (bus.br_target_i[1:0] == 2'b00);
  assign redirect_go = accept && bus.br_taken_i && aligned;
  assign handshake   = (state == REDIRECT) && bus.redirect_ready_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: default assignment first, so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (redirect_go) state_next = REDIRECT;
      REDIRECT: if (handshake)   state_next = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
      FLUSH:    if (!bus.stall_i && flush_cnt == 4'd1) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Flush is decoded from registered state only, never from live inputs.
  always_comb begin
    bus.br_ready_o       = ready;
    bus.redirect_valid_o = (state == REDIRECT);
    bus.flush_o          = (state == REDIRECT) || (state == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flush_cnt    <= 4'd0;
      redirect_pc  <= 32'd0;
      misalign     <= 1'b0;
      resolved_cnt <= '0;
      taken_cnt    <= '0;
    end else begin
      misalign <= accept && bus.br_taken_i && !aligned;
      if (redirect_go) redirect_pc <= bus.br_target_i;

      if (handshake)
        flush_cnt <= 4'(FLUSH_CYCLES);
      else if (state == FLUSH && !bus.stall_i)
        flush_cnt <= flush_cnt - 4'd1;

      if (accept && resolved_cnt != '1)
        resolved_cnt <= resolved_cnt + CNT_ONE;
      if (redirect_go && taken_cnt != '1)
        taken_cnt <= taken_cnt + CNT_ONE;
    end
  end

  assign bus.redirect_pc_o  = redirect_pc;
  assign bus.misalign_o     = misalign;
  assign bus.resolved_cnt_o = resolved_cnt;
  assign bus.taken_cnt_o    = taken_cnt;

endmodule

// File: tb/tb_yarp_branch_redirect_ctrl.sv
// Directed bench for yarp_branch_redirect_ctrl: default build plus a
// FLUSH_CYCLES=0 build and a CNT_W=4 build for saturation.
module tb_yarp_branch_redirect_ctrl;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  yarp_branch_redirect_ctrl_if #(.CNT_W(16)) bus  ();
  yarp_branch_redirect_ctrl_if #(.CNT_W(16)) bus0 ();
  yarp_branch_redirect_ctrl_if #(.CNT_W(4))  bus4 ();

  yarp_branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master));
  yarp_branch_redirect_ctrl #(.FLUSH_CYCLES(0), .CNT_W(16)) dut_f0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.master));
  yarp_branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 2 time units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.br_valid_i  = 0; bus.br_taken_i  = 0; bus.br_target_i  = 0; bus.stall_i  = 0; bus.redirect_ready_i  = 0;
    bus0.br_valid_i = 0; bus0.br_taken_i = 0; bus0.br_target_i = 0; bus0.stall_i = 0; bus0.redirect_ready_i = 0;
    bus4.br_valid_i = 0; bus4.br_taken_i = 0; bus4.br_target_i = 0; bus4.stall_i = 0; bus4.redirect_ready_i = 0;

    // Reset values
    tick(); tick();
    check("rst_ready",    bus.br_ready_o, 0);
    check("rst_valid",    bus.redirect_valid_o, 0);
    check("rst_flush",    bus.flush_o, 0);
    check("rst_misalign", bus.misalign_o, 0);
    check("rst_pc",       bus.redirect_pc_o, 0);
    check("rst_resolved", bus.resolved_cnt_o, 0);
    check("rst_taken",    bus.taken_cnt_o, 0);
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", bus.br_ready_o, 1);

    // Not-taken back-to-back
    bus.br_valid_i = 1; bus.br_taken_i = 0; bus.br_target_i = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("nt_ready", bus.br_ready_o, 1);
      tick();
      check("nt_flush", bus.flush_o, 0);
      check("nt_valid", bus.redirect_valid_o, 0);
    end
    bus.br_valid_i = 0;
    check("nt_resolved", bus.resolved_cnt_o, 3);
    check("nt_taken",    bus.taken_cnt_o, 0);

    // Taken, fetch ready immediately
    bus.br_valid_i = 1; bus.br_taken_i = 1; bus.br_target_i = 32'h0000_1004; bus.redirect_ready_i = 1;
    tick();
    bus.br_valid_i = 0;
    #1;
    check("tk_valid1", bus.redirect_valid_o, 1);
    check("tk_pc",     bus.redirect_pc_o, 32'h0000_1004);
    check("tk_flush1", bus.flush_o, 1);
    check("tk_ready1", bus.br_ready_o, 0);
    check("tk_taken",  bus.taken_cnt_o, 1);
    check("tk_resolved", bus.resolved_cnt_o, 4);
    tick();
    check("tk_valid2", bus.redirect_valid_o, 0);
    check("tk_flush2", bus.flush_o, 1);
    check("tk_ready2", bus.br_ready_o, 0);
    tick();
    check("tk_flush3", bus.flush_o, 1);
    check("tk_ready3", bus.br_ready_o, 0);
    tick();
    check("tk_flush4", bus.flush_o, 0);
    check("tk_ready4", bus.br_ready_o, 1);
    bus.redirect_ready_i = 0;

    // Fetch backpressure for 4 cycles with a stall in REDIRECT, then stall in FLUSH
    bus.br_valid_i = 1; bus.br_taken_i = 1; bus.br_target_i = 32'h0000_2000;
    tick();
    bus.br_valid_i = 0; bus.br_target_i = 32'hDEAD_BEE0;
    for (int i = 0; i < 4; i++) begin
      bus.stall_i = (i == 1 || i == 2);
      #1;
      check("bp_valid", bus.redirect_valid_o, 1);
      check("bp_pc",    bus.redirect_pc_o, 32'h0000_2000);
      check("bp_ready", bus.br_ready_o, 0);
      if (i < 3) tick();
    end
    bus.redirect_ready_i = 1;
    tick();
    bus.redirect_ready_i = 0;
    bus.stall_i = 1;
    check("fl_valid", bus.redirect_valid_o, 0);
    check("fl_flush_a", bus.flush_o, 1);
    tick();
    check("fl_flush_b", bus.flush_o, 1);
    tick();
    bus.stall_i = 0;
    check("fl_flush_c", bus.flush_o, 1);
    tick();
    check("fl_flush_d", bus.flush_o, 1);
    tick();
    #1;
    check("fl_flush_end", bus.flush_o, 0);
    check("fl_ready_end", bus.br_ready_o, 1);
    check("fl_resolved",  bus.resolved_cnt_o, 5);
    check("fl_taken",     bus.taken_cnt_o, 2);

    // Stall in IDLE blocks acceptance
    bus.stall_i = 1; bus.br_valid_i = 1; bus.br_taken_i = 0;
    #1;
    check("stall_ready", bus.br_ready_o, 0);
    tick();
    check("stall_resolved", bus.resolved_cnt_o, 5);
    bus.stall_i = 0; bus.br_valid_i = 0;

    // Misaligned taken target
    bus.br_valid_i = 1; bus.br_taken_i = 1; bus.br_target_i = 32'h0000_1002;
    tick();
    bus.br_valid_i = 0;
    check("mis_pulse",    bus.misalign_o, 1);
    check("mis_valid",    bus.redirect_valid_o, 0);
    check("mis_flush",    bus.flush_o, 0);
    check("mis_pc",       bus.redirect_pc_o, 32'h0000_2000);
    check("mis_taken",    bus.taken_cnt_o, 2);
    check("mis_resolved", bus.resolved_cnt_o, 6);
    tick();
    check("mis_clear",    bus.misalign_o, 0);
    check("mis_flush2",   bus.flush_o, 0);

    // Reset while in REDIRECT
    bus.br_valid_i = 1; bus.br_taken_i = 1; bus.br_target_i = 32'h0000_3000;
    tick();
    bus.br_valid_i = 0;
    check("rr_valid_pre", bus.redirect_valid_o, 1);
    reset_n = 1'b0;
    tick();
    check("rr_valid",    bus.redirect_valid_o, 0);
    check("rr_flush",    bus.flush_o, 0);
    check("rr_pc",       bus.redirect_pc_o, 0);
    check("rr_resolved", bus.resolved_cnt_o, 0);
    check("rr_taken",    bus.taken_cnt_o, 0);
    check("rr_ready",    bus.br_ready_o, 0);
    reset_n = 1'b1;
    tick();
    check("rr_after_valid", bus.redirect_valid_o, 0);
    check("rr_after_flush", bus.flush_o, 0);

    // Reset while in FLUSH
    bus.br_valid_i = 1; bus.br_taken_i = 1; bus.br_target_i = 32'h0000_3000; bus.redirect_ready_i = 1;
    tick();
    bus.br_valid_i = 0;
    tick();
    check("rf_flush_pre", bus.flush_o, 1);
    check("rf_valid_pre", bus.redirect_valid_o, 0);
    reset_n = 1'b0;
    tick();
    check("rf_flush", bus.flush_o, 0);
    check("rf_pc",    bus.redirect_pc_o, 0);
    check("rf_taken", bus.taken_cnt_o, 0);
    reset_n = 1'b1;
    bus.redirect_ready_i = 0;
    tick();
    check("rf_after_flush", bus.flush_o, 0);
    check("rf_after_valid", bus.redirect_valid_o, 0);
    check("rf_after_ready", bus.br_ready_o, 1);

    // FLUSH_CYCLES = 0: handshake returns straight to IDLE
    bus0.br_valid_i = 1; bus0.br_taken_i = 1; bus0.br_target_i = 32'h0000_4000; bus0.redirect_ready_i = 1;
    tick();
    bus0.br_valid_i = 0;
    check("f0_valid", bus0.redirect_valid_o, 1);
    check("f0_flush", bus0.flush_o, 1);
    check("f0_pc",    bus0.redirect_pc_o, 32'h0000_4000);
    tick();
    check("f0_flush_end", bus0.flush_o, 0);
    check("f0_valid_end", bus0.redirect_valid_o, 0);
    check("f0_ready_end", bus0.br_ready_o, 1);

    // CNT_W = 4: 20 taken branches saturate both counters at 15
    bus4.br_taken_i = 1; bus4.br_target_i = 32'h0000_0100; bus4.redirect_ready_i = 1;
    for (int i = 0; i < 20; i++) begin
      bus4.br_valid_i = 1;
      tick();
      bus4.br_valid_i = 0;
      if (i == 13) check("c4_taken_14", bus4.taken_cnt_o, 14);
      tick(); tick(); tick();
    end
    check("c4_taken_sat",    bus4.taken_cnt_o, 15);
    check("c4_resolved_sat", bus4.resolved_cnt_o, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
